div_16x8_restoring_seq: RTL and testbench

//   Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//   It is the inverse of the 8x8 array multipliers in the synthetic arithmetic suite.
//   A bench can multiply a[7:0] by b[7:0], then divide the product by b and recover a with remainder 0.

---
 rtl/arith_pkg.sv | 13 +
 rtl/div_restore_step.sv | 22 ++
 rtl/div_16x8_restoring_seq.sv | 93 +++++++++
 tb/tb_div_16x8_restoring_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the synthetic arithmetic suite: divider FSM states and default widths.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module div_restore_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  // The incoming remainder is always below the divisor, so the widened trial never loses a bit.
  logic [DIVISOR_W+1:0] w_trial;
  logic [DIVISOR_W+1:0] w_div_ext;

  assign w_trial   = {r_in, q_msb};
  assign w_div_ext = {2'b00, divisor};
  assign q_bit     = (w_trial >= w_div_ext);
  assign r_out     = q_bit ? (DIVISOR_W+1)'(w_trial - w_div_ext) : (DIVISOR_W+1)'(w_trial);

endmodule

// File: rtl/div_16x8_restoring_seq.sv
// Sequential unsigned restoring divider with valid/ready operand and result handshakes.
// One iteration per cycle reusing a single div_restore_step; one operation in flight.
module div_16x8_restoring_seq
  import arith_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t            r_state;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W:0]    r_r;
  logic [DIVISOR_W-1:0]  r_div;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;

  logic [DIVISOR_W:0]    w_r_next;
  logic                  w_q_bit;

  // r_q starts as the dividend and fills with quotient bits from the LSB as dividend bits leave the MSB.
  div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in    (r_r),
    .q_msb   (r_q[DIVIDEND_W-1]),
    .divisor (r_div),
    .r_out   (w_r_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_r   <= '0;
            r_cnt <= '0;
            if (divisor != '0) begin
              r_q     <= dividend;
              r_div   <= divisor;
              r_state <= ST_BUSY;
            end else begin
              r_q     <= '1;
              r_div   <= '0;
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          r_r   <= w_r_next;
          r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIVIDEND_W - 1))
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_dbz   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_q;
  assign remainder   = r_r[DIVISOR_W-1:0];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_16x8_restoring_seq.sv
// Directed and randomized checks of the sequential restoring divider.
module tb_div_16x8_restoring_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  div_16x8_restoring_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for the result and check it; the result is left pending.
  task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input logic [15:0] exp_q, input logic [7:0] exp_r, input logic exp_dbz,
                        input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    tick();
    // Garbage on the inputs while busy must be ignored.
    dividend = ~dd;
    divisor  = ~dv;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".q"}, quotient, exp_q);
    chk({tag, ".r"}, remainder, exp_r);
    chk({tag, ".dbz"}, div_by_zero, exp_dbz);
    chk({tag, ".busy_rdy"}, in_ready, 0);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, out_valid, 0);
    chk({tag, ".rdy_up"}, in_ready, 1);
    chk({tag, ".dbz_clr"}, div_by_zero, 0);
  endtask

  initial begin
    logic [15:0] dd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] prod;

    rst       = 1'b1;
    in_valid  = 1'bx;
    out_ready = 1'bx;
    dividend  = 16'h0;
    divisor   = 8'h0;
    tick();
    tick();
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.dbz", div_by_zero, 0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("idle.in_ready", in_ready, 1);
    chk("idle.out_valid", out_valid, 0);

    run_op("t1", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
    handoff("t1");

    run_op("t2a", 16'hFFFF, 8'hFF, 16'h0101, 8'd0, 1'b0, 17);
    handoff("t2a");
    run_op("t2b", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17);
    handoff("t2b");
    run_op("t2c", 16'hBEEF, 8'd1, 16'hBEEF, 8'd0, 1'b0, 17);
    handoff("t2c");

    run_op("t3", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
    handoff("t3");

    run_op("t4", 16'd300, 8'd10, 16'd30, 8'd0, 1'b0, 17);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4.hold_q", quotient, 30);
      chk("t4.hold_r", remainder, 0);
      chk("t4.hold_ov", out_valid, 1);
      chk("t4.hold_rdy", in_ready, 0);
    end
    handoff("t4");

    // Reset in the middle of a division.
    in_valid = 1'b1;
    dividend = 16'd5000;
    divisor  = 8'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5.busy", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5.in_ready", in_ready, 1);
    chk("t5.out_valid", out_valid, 0);
    chk("t5.q", quotient, 0);
    chk("t5.r", remainder, 0);
    chk("t5.dbz", div_by_zero, 0);
    run_op("t5b", 16'd99, 8'd4, 16'd24, 8'd3, 1'b0, 17);
    handoff("t5b");

    for (int i = 0; i < 1500; i++) begin
      if (i % 2 == 0) begin
        a    = 8'($urandom_range(0, 255));
        b    = 8'($urandom_range(1, 255));
        prod = 32'(a) * 32'(b);
        run_op("rnd_mul", prod[15:0], b, {8'h00, a}, 8'd0, 1'b0, 17);
        handoff("rnd_mul");
      end else begin
        dd = 16'($urandom);
        b  = (i % 51 == 1) ? 8'd0 : 8'($urandom_range(0, 255));
        if (b == 8'd0) begin
          run_op("rnd_dbz", dd, b, 16'hFFFF, 8'd0, 1'b1, 1);
        end else begin
          run_op("rnd", dd, b, dd / {8'h00, b}, 8'(dd % {8'h00, b}), 1'b0, 17);
          chk("rnd.inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(dd));
        end
        handoff("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
